// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT_M0, GNT_M1, DRAIN} arb_state_t;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/wb_ack_counter.sv
// Outstanding-request counter: saturates at MAX, never underflows.
module wb_ack_counter #(
  parameter int MAX = 4,
  localparam int CW = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          cnt_next_zero
);
  logic          inc_ok, dec_ok;
  logic [CW-1:0] cnt_nxt;

  assign full   = (cnt == CW'(MAX));
  assign inc_ok = inc & ~full;
  // an ack with nothing outstanding is stale (e.g. from before reset)
  assign dec_ok = dec & (cnt != '0);

  always_comb begin
    cnt_nxt = cnt;
    if (inc_ok && !dec_ok)      cnt_nxt = cnt + CW'(1);
    else if (dec_ok && !inc_ok) cnt_nxt = cnt - CW'(1);
  end

  assign cnt_next_zero = (cnt_nxt == '0);

  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else        cnt <= cnt_nxt;
endmodule

// File: rtl/wb_arbiter2.sv
// Two-master (data m0, fetch m1) to one-slave pipelined Wishbone B4 arbiter.
// Ownership changes only after all accepted requests have been acked.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_m0_cyc,
  input  logic                i_m0_stb,
  input  logic                i_m0_we,
  input  logic [DATA_W/8-1:0] i_m0_sel,
  input  logic [ADDR_W-1:0]   i_m0_addr,
  input  logic [DATA_W-1:0]   i_m0_data,
  output logic                o_m0_ack,
  output logic                o_m0_stall,
  output logic [DATA_W-1:0]   o_m0_data,
  input  logic                i_m1_cyc,
  input  logic                i_m1_stb,
  input  logic                i_m1_we,
  input  logic [DATA_W/8-1:0] i_m1_sel,
  input  logic [ADDR_W-1:0]   i_m1_addr,
  input  logic [DATA_W-1:0]   i_m1_data,
  output logic                o_m1_ack,
  output logic                o_m1_stall,
  output logic [DATA_W-1:0]   o_m1_data,
  output logic                o_s_cyc,
  output logic                o_s_stb,
  output logic                o_s_we,
  output logic [DATA_W/8-1:0] o_s_sel,
  output logic [ADDR_W-1:0]   o_s_addr,
  output logic [DATA_W-1:0]   o_s_data,
  input  logic                i_s_ack,
  input  logic                i_s_stall,
  input  logic [DATA_W-1:0]   i_s_data
);
  localparam int CW = $clog2(MAX_OUTST + 1);

  arb_state_t    state, nxt;
  logic          last_grant, lg_nxt;
  logic [CW-1:0] cnt;
  logic          full, cnt_next_zero, ack_ok;
  logic          own_m1, own_cyc, own_stb;

  wb_ack_counter #(.MAX(MAX_OUTST)) u_cnt (
    .clk           (clk),
    .reset         (reset),
    .inc           (o_s_stb & ~i_s_stall),
    .dec           (i_s_ack),
    .cnt           (cnt),
    .full          (full),
    .cnt_next_zero (cnt_next_zero)
  );

  assign o_m0_data = i_s_data;
  assign o_m1_data = i_s_data;
  assign ack_ok    = i_s_ack & (cnt != '0);
  assign own_m1    = (state == GNT_M1);
  assign own_cyc   = own_m1 ? i_m1_cyc : i_m0_cyc;
  assign own_stb   = own_m1 ? i_m1_stb : i_m0_stb;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      last_grant <= M1;
    end else begin
      state      <= nxt;
      last_grant <= lg_nxt;
    end

  always_comb begin
    nxt        = state;
    lg_nxt     = last_grant;
    o_s_cyc    = 1'b0;
    o_s_stb    = 1'b0;
    o_s_we     = 1'b0;
    o_s_sel    = '0;
    o_s_addr   = '0;
    o_s_data   = '0;
    o_m0_stall = 1'b1;
    o_m1_stall = 1'b1;
    o_m0_ack   = 1'b0;
    o_m1_ack   = 1'b0;
    case (state)
      IDLE: begin
        // on a tie, the master that did not win last time gets the bus
        if (i_m0_cyc && (!i_m1_cyc || last_grant == M1)) begin
          nxt    = GNT_M0;
          lg_nxt = M0;
        end else if (i_m1_cyc) begin
          nxt    = GNT_M1;
          lg_nxt = M1;
        end
      end
      GNT_M0, GNT_M1: begin
        o_s_cyc  = own_cyc;
        o_s_stb  = own_cyc & own_stb & ~full;
        o_s_we   = own_m1 ? i_m1_we   : i_m0_we;
        o_s_sel  = own_m1 ? i_m1_sel  : i_m0_sel;
        o_s_addr = own_m1 ? i_m1_addr : i_m0_addr;
        o_s_data = own_m1 ? i_m1_data : i_m0_data;
        if (own_m1) begin
          o_m1_stall = i_s_stall | full;
          o_m1_ack   = ack_ok;
        end else begin
          o_m0_stall = i_s_stall | full;
          o_m0_ack   = ack_ok;
        end
        if (!own_cyc) nxt = cnt_next_zero ? IDLE : DRAIN;
      end
      DRAIN: begin
        // keep cyc up so the slave can finish; its acks go nowhere
        o_s_cyc = 1'b1;
        if (cnt_next_zero) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master to one-slave pipelined Wishbone (B4) arbiter placed directly below the CPU top.
- Merges the instruction-fetch bus (wb2_*) and the data bus (wb_*) onto a single memory port.
- Tracks outstanding requests so that aborted cycles (fetch flush on branch) drain cleanly before the bus changes owner.
- Arbitration is per-cycle (cyc) granularity, round-robin on ties.

Parameters:
ADDR_W, 30, word address width
DATA_W, 32, data width (sel width = DATA_W/8)
MAX_OUTST, 4, max accepted-but-unacked requests; counter width = $clog2(MAX_OUTST+1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
i_m0_cyc, i_m0_stb, i_m0_we  input  1 each  master 0 (data/mem stage) control
i_m0_sel  input  DATA_W/8  m0 byte select
i_m0_addr  input  ADDR_W  m0 address
i_m0_data  input  DATA_W  m0 write data
o_m0_ack, o_m0_stall  output  1 each  m0 handshake
o_m0_data  output  DATA_W  m0 read data
i_m1_* / o_m1_*  same set  master 1 (fetch)
o_s_cyc, o_s_stb, o_s_we  output  1 each  slave control
o_s_sel  output  DATA_W/8  slave byte select
o_s_addr  output  ADDR_W  slave address
o_s_data  output  DATA_W  slave write data
i_s_ack, i_s_stall  input  1 each  slave handshake
i_s_data  input  DATA_W  slave read data

Behaviour:
- Registered state: IDLE, GNT_M0, GNT_M1, DRAIN; outstanding count cnt; last_grant bit.
- Reset (reset low, async): state=IDLE, cnt=0, last_grant=M1 (so M0 wins the first tie). All outputs derive combinationally from state, so during reset s_cyc=s_stb=0, both acks=0, both stalls=1.
- IDLE:
  - s_cyc=0, s_stb=0; o_mX_stall=1, o_mX_ack=0.
  - Next state is GNT_M0 if only m0_cyc, GNT_M1 if only m1_cyc.
  - If both are asserted, grant the master != last_grant; last_grant updates on grant.
  - Arbitration latency is one cycle: a request first seen in IDLE is stalled that cycle.
- GNT_x (owner x):
  - s_cyc=mx_cyc; s_stb=mx_stb & ~full; we/sel/addr/data muxed from owner.
  - o_mx_stall = i_s_stall | full; o_mx_ack = i_s_ack.
  - Non-owner: stall=1, ack=0.
  - full = (cnt==MAX_OUTST).
  - When mx_cyc=0: go to IDLE if cnt_next==0, else DRAIN.
- DRAIN:
  - s_cyc=1, s_stb=0; acks absorbed (forwarded to nobody); both stalls=1.
  - Go to IDLE when cnt_next==0.
  - New requests are not granted until then.
- o_m0_data = o_m1_data = i_s_data (ungated; validity is qualified by ack).
- cnt update:
  - +1 on (o_s_stb & ~i_s_stall); -1 on i_s_ack.
  - Both in the same cycle: unchanged.
  - Ack with cnt==0 is ignored (no underflow, not forwarded).
  - cnt never exceeds MAX_OUTST.
- Owner releases the bus with one IDLE turnaround cycle minimum; no direct GNT_M0 to GNT_M1 transition.
- Owner may drop stb while keeping cyc: grant is held.
- Reset mid-transaction: immediate return to IDLE, cnt=0; late slave acks after reset are dropped by the cnt==0 rule.

Decomposition:
- Package wb_arb_pkg: typedef enum logic [1:0] arb_state_t {IDLE, GNT_M0, GNT_M1, DRAIN}; localparam bits M0=0, M1=1.
- Sub-module wb_ack_counter:
  - Parameter MAX.
  - Inputs inc, dec.
  - Outputs cnt, full, cnt_next_zero.
  - Implements the saturating/underflow-safe count.
- Arbiter FSM and muxing stay in wb_arbiter2.

Test Plan:
- Single master: m1 cyc+stb addr 0x100, slave ack 1 cycle after accept -> IDLE one cycle, then o_s_addr=0x100, o_m1_ack pulses once, o_m1_data=i_s_data, return to IDLE after cyc drop.
- Tie after reset: m0 and m1 raise cyc in the same cycle -> GNT_M0 first. After m0 drops cyc, m1 (still requesting) gets GNT_M1. Repeat the tie -> m1 is not starved; alternation holds.
- Pipelined burst: m0 issues 6 stb back-to-back, slave acks with 3-cycle latency, MAX_OUTST=4 -> o_m0_stall forced high when cnt=4, exactly 6 acks delivered in order, cnt returns to 0.
- Abort/drain: m1 issues 3 reads, drops cyc after 1 ack (flush) while m0 requests -> DRAIN absorbs remaining 2 acks (o_m1_ack=0, o_m0_ack=0), then IDLE, then GNT_M0.
- Simultaneous inc/dec: accept and ack in the same cycle for 10 cycles -> cnt constant; spurious ack at cnt=0 -> ignored, no ack forwarded.
- Reset mid-burst: assert reset low with cnt=3 -> o_s_cyc=0 immediately (async), state=IDLE, cnt=0. Post-reset stray acks are not forwarded.
